alu_muldiv_seq: RTL and testbench

//  Next-generation execute-stage ALU: registered, WIDTH-parametrised ALU plus iterative

---
 rtl/alu_muldiv_seq.sv | 183 ++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Execute-stage ALU with an iterative multiply/divide unit.
// Ops 0-11 finish in one cycle into out/cond. MULT/DIV run a one-bit-per-cycle
// datapath on operand magnitudes for WIDTH cycles, then FIX applies the signs
// and writes hi/lo. Issue is blocked (in_ready low) from the cycle after a
// MULT/DIV is accepted until the FSM is back in IDLE.
module alu_muldiv_seq #(
   parameter int WIDTH = 32,
   parameter int SH_W  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_fn,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   output logic [WIDTH-1:0] out,
   output logic [5:0]       cond,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy
);
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   opa_q, opa_d;     // raw in1, needed for divide-by-zero remainder
   logic [WIDTH-1:0]   mb_q, mb_d;       // |multiplicand| or |divisor|
   logic [2*WIDTH-1:0] acc_q, acc_d;     // MUL: {partial sum, multiplier}; DIV: {rem, quotient}
   logic               neg_a_q, neg_a_d;
   logic               neg_b_q, neg_b_d;
   logic               is_div_q, is_div_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [5:0]         cond_q, cond_d;
   logic               out_valid_q, out_valid_d;

   logic [SH_W-1:0]    sh, sh_neg;
   logic [WIDTH-1:0]   alu_res;
   logic [5:0]         cond_now;
   logic [WIDTH:0]     mul_sum, div_shift, div_trial;
   logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = ~in_ready;
   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign cond      = cond_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

   // Single-cycle ALU result and condition flags from the live operands
   always_comb begin
      sh       = in1[SH_W-1:0];
      sh_neg   = -sh;                    // (WIDTH - sh) mod WIDTH for the rotate
      cond_now = {in1 < in2, in1 == in2, in1 > in2, in1[WIDTH-1], in1 == '0,
                  ~in1[WIDTH-1] & (in1 != '0)};
      case (alu_fn)
         4'd0:    alu_res = in1 + in2;
         4'd1:    alu_res = in1 - in2;
         4'd2:    alu_res = in2 << sh;
         4'd3:    alu_res = in2 >> sh;
         4'd4:    alu_res = $unsigned($signed(in2) >>> sh);
         4'd5:    alu_res = (in2 >> sh) | (in2 << sh_neg);
         4'd6:    alu_res = in1 & in2;
         4'd7:    alu_res = in1 | in2;
         4'd8:    alu_res = in1 ^ in2;
         4'd9:    alu_res = ~(in1 | in2);
         4'd10:   alu_res = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
         4'd11:   alu_res = {{(WIDTH-1){1'b0}}, in1 < in2};
         default: alu_res = '0;
      endcase
   end

   // One shift-add step, one restoring-divide step, and the signed product
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mb_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_trial = div_shift - {1'b0, mb_q};
      div_next  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      prod_fix  = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
   end

   // FSM next-state and datapath updates
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      opa_d       = opa_q;
      mb_d        = mb_q;
      acc_d       = acc_q;
      neg_a_d     = neg_a_q;
      neg_b_d     = neg_b_q;
      is_div_d    = is_div_q;
      out_d       = out_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      cond_d      = cond_q;
      out_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (alu_fn < 4'd12) begin
                  out_d       = alu_res;
                  cond_d      = cond_now;
                  out_valid_d = 1'b1;
               end else begin
                  // odd codes are the unsigned variants
                  neg_a_d  = ~alu_fn[0] & in1[WIDTH-1];
                  neg_b_d  = ~alu_fn[0] & in2[WIDTH-1];
                  opa_d    = in1;
                  acc_d    = {{WIDTH{1'b0}}, (neg_a_d ? -in1 : in1)};
                  mb_d     = neg_b_d ? -in2 : in2;
                  is_div_d = alu_fn[1];
                  cnt_d    = '0;
                  state_d  = alu_fn[1] ? S_DIV : S_MUL;
               end
            end
         end
         S_MUL, S_DIV: begin
            acc_d = (state_q == S_DIV) ? div_next : mul_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (is_div_q) begin
               if (mb_q == '0) begin
                  lo_d = '1;
                  hi_d = opa_q;
               end else begin
                  lo_d = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                  hi_d = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
               end
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset aborts any operation in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         opa_q       <= '0;
         mb_q        <= '0;
         acc_q       <= '0;
         neg_a_q     <= 1'b0;
         neg_b_q     <= 1'b0;
         is_div_q    <= 1'b0;
         out_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         cond_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         opa_q       <= opa_d;
         mb_q        <= mb_d;
         acc_q       <= acc_d;
         neg_a_q     <= neg_a_d;
         neg_b_q     <= neg_b_d;
         is_div_q    <= is_div_d;
         out_q       <= out_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         cond_q      <= cond_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq (WIDTH=32): the driver predicts each
// accepted op with an arithmetic reference model and queues it; the monitor
// pops and compares whenever out_valid is seen, including the arrival cycle.
module tb_alu_muldiv_seq;
   localparam int W = 32;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [3:0]  alu_fn = 4'd0;
   logic [31:0] in1 = '0, in2 = '0;
   logic        in_ready, out_valid, busy;
   logic [31:0] out, hi, lo;
   logic [5:0]  cond;

   alu_muldiv_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .alu_fn(alu_fn), .in1(in1), .in2(in2), .out_valid(out_valid), .out(out),
      .cond(cond), .hi(hi), .lo(lo), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          md;
      logic [31:0] out, hi, lo;
      logic [5:0]  cond;
      int          due;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0, n_bad = 0;
   logic [31:0] m_out = '0, m_hi = '0, m_lo = '0;
   int          free_cyc = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      int s;
      s = int'(a[4:0]);
      case (fn)
         4'd0:  r = a + b;
         4'd1:  r = a - b;
         4'd2:  r = b << s;
         4'd3:  r = b >> s;
         4'd4:  r = $signed(b) >>> s;
         4'd5:  begin r = b; repeat (s) r = {r[0], r[31:1]}; end
         4'd6:  r = a & b;
         4'd7:  r = a | b;
         4'd8:  r = a ^ b;
         4'd9:  r = ~(a | b);
         4'd10: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd11: r = (a < b) ? 32'd1 : 32'd0;
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [5:0] ref_cond(input logic [31:0] a, input logic [31:0] b);
      return {a < b, a == b, a > b, $signed(a) < 0, a == 0, $signed(a) > 0};
   endfunction

   task automatic ref_md(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l);
      longint      sp;
      logic [63:0] up;
      case (fn)
         4'd12: begin sp = longint'($signed(a)) * longint'($signed(b)); {h, l} = sp; end
         4'd13: begin up = {32'd0, a} * {32'd0, b}; {h, l} = up; end
         4'd14: begin
            if (b == 0) begin l = '1; h = a; end
            else begin
               sp = longint'($signed(a)) / longint'($signed(b)); l = sp[31:0];
               sp = longint'($signed(a)) % longint'($signed(b)); h = sp[31:0];
            end
         end
         default: begin
            if (b == 0) begin l = '1; h = a; end
            else begin l = a / b; h = a % b; end
         end
      endcase
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   // One cycle of stimulus; acceptance is decided by the bench's own ready model
   task automatic do_cycle(input bit v, input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      bit   rdy;
      @(negedge clk); #1;
      rdy = (cyc >= free_cyc);
      chk("in_ready", 64'(in_ready), 64'(rdy));
      chk("busy", 64'(busy), 64'(!rdy));
      in_valid = v; alu_fn = fn; in1 = a; in2 = b;
      if (v && rdy) begin
         if (fn < 4'd12) begin
            e.md = 1'b0; e.out = ref_alu(fn, a, b); e.cond = ref_cond(a, b);
            e.hi = m_hi; e.lo = m_lo; e.due = cyc + 1;
            m_out = e.out;
         end else begin
            ref_md(fn, a, b, m_hi, m_lo);
            e.md = 1'b1; e.out = m_out; e.cond = '0; e.hi = m_hi; e.lo = m_lo;
            e.due = cyc + W + 2;
            free_cyc = cyc + W + 2;
         end
         sb.push_back(e);
      end
   endtask

   task automatic busy_noise();
      repeat (W + 1) do_cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);
   endtask

   // Monitor: every out_valid pulse must match the oldest prediction
   always @(negedge clk) begin
      exp_t e;
      if (out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_out_valid: got pulse expected none (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            chk("latency", 64'(cyc), 64'(e.due));
            chk("out", 64'(out), 64'(e.out));
            if (!e.md) chk("cond", 64'(cond), 64'(e.cond));
            chk("hi", 64'(hi), 64'(e.hi));
            chk("lo", 64'(lo), 64'(e.lo));
         end
      end
   end

   initial begin
      int k;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out", 64'(out), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_cond", 64'(cond), 64'd0);
      #1 reset = 1'b0;

      // back-to-back single-cycle ops
      do_cycle(1, 4'd0, 32'hFFFF_FFFF, 32'h1);
      do_cycle(1, 4'd4, 32'd4, 32'h8000_0000);
      // multiply with ignored issue attempts while busy
      do_cycle(1, 4'd12, 32'hFFFF_FFFD, 32'd7);
      busy_noise();
      do_cycle(1, 4'd14, 32'hFFFF_FFF9, 32'd2); busy_noise();
      do_cycle(1, 4'd15, 32'd7, 32'd2);         busy_noise();
      do_cycle(1, 4'd15, 32'd5, 32'd0);         busy_noise();
      do_cycle(1, 4'd14, 32'hFFFF_FFF9, 32'd0); busy_noise();
      do_cycle(1, 4'd14, 32'h8000_0000, 32'hFFFF_FFFF); busy_noise();
      do_cycle(1, 4'd12, 32'h8000_0000, 32'h8000_0000); busy_noise();
      do_cycle(1, 4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF); busy_noise();
      do_cycle(1, 4'd5, 32'h24, 32'hF1);
      do_cycle(1, 4'd11, 32'h1, 32'hFFFF_FFFF);
      do_cycle(1, 4'd10, 32'h1, 32'hFFFF_FFFF);

      // reset in cycle 10 of a MULTU aborts it without a result pulse
      do_cycle(1, 4'd13, $urandom, $urandom);
      repeat (9) do_cycle(0, 4'd0, '0, '0);
      @(negedge clk); #1;
      in_valid = 1'b0; reset = 1'b1;
      sb.delete(); m_hi = '0; m_lo = '0; m_out = '0; free_cyc = 0;
      @(negedge clk);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      #1 reset = 1'b0;
      repeat (W + 4) do_cycle(0, 4'd0, '0, '0);

      // randomized mix, issue attempts arrive regardless of busy
      repeat (400) do_cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), pick(), pick());

      @(negedge clk); #1 in_valid = 1'b0;
      k = 0;
      while (sb.size() != 0 && k < 100) begin @(negedge clk); k++; end
      if (sb.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain: got %0d pending results expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
